// File: rtl/addr_unit_if.sv
// Strobe and address/data bundle between the microcoded controller and the address unit.
// The controller side uses the master modport; addr_unit uses the slave modport.
interface addr_unit_if;
    logic [7:0]  bus_in;
    logic        mreg_h_load;
    logic        mreg_l_load;
    logic        cnt_en;
    logic        cnt_wr;
    logic        cnt_l_out;
    logic        cnt_h_out;
    logic        ram_read_pc;
    logic        ram_read_mreg;
    logic        ram_write;
    logic        halt;
    logic [15:0] addr;
    logic [7:0]  bus_out;
    logic        bus_out_en;
    logic [15:0] pc;
    logic [15:0] mreg;
    logic        halted;
    logic        pc_wrap;
    logic        strobe_err;

    modport master (
        output bus_in, mreg_h_load, mreg_l_load, cnt_en, cnt_wr, cnt_l_out,
               cnt_h_out, ram_read_pc, ram_read_mreg, ram_write, halt,
        input  addr, bus_out, bus_out_en, pc, mreg, halted, pc_wrap, strobe_err
    );

    modport slave (
        input  bus_in, mreg_h_load, mreg_l_load, cnt_en, cnt_wr, cnt_l_out,
               cnt_h_out, ram_read_pc, ram_read_mreg, ram_write, halt,
        output addr, bus_out, bus_out_en, pc, mreg, halted, pc_wrap, strobe_err
    );
endinterface

// File: rtl/addr_unit.sv
// Program counter and memory address register of the 8-bit core, with RAM address mux,
// PC byte output, sticky halt, PC wrap pulse and sticky illegal-strobe detection.
module addr_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input logic        clk,
    input logic        reset,
    addr_unit_if.slave au
);
    logic [15:0] pc_q;
    logic [15:0] mreg_q;
    logic        halted_q;
    logic        wrap_q;
    logic        err_q;
    logic        bad_strobe;

    assign bad_strobe = (au.ram_read_pc & (au.ram_read_mreg | au.ram_write))
                      | (au.cnt_l_out & au.cnt_h_out)
                      | (au.ram_read_mreg & au.ram_write);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            mreg_q   <= 16'h0000;
            halted_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (au.halt)
                halted_q <= 1'b1;
            if (bad_strobe)
                err_q <= 1'b1;
            if (!halted_q) begin
                // Jump takes the MREG value from before this edge and beats the increment.
                if (au.cnt_wr) begin
                    pc_q <= mreg_q;
                end else if (au.cnt_en) begin
                    pc_q   <= pc_q + 16'd1;
                    wrap_q <= (pc_q == 16'hFFFF);
                end
                if (au.mreg_h_load)
                    mreg_q[15:8] <= au.bus_in;
                if (au.mreg_l_load)
                    mreg_q[7:0] <= au.bus_in;
            end
        end
    end

    always_comb begin
        au.addr = pc_q;
        if (au.ram_read_pc)
            au.addr = pc_q;
        else if (au.ram_read_mreg || au.ram_write)
            au.addr = mreg_q;
    end

    always_comb begin
        au.bus_out    = 8'h00;
        au.bus_out_en = 1'b0;
        if (au.cnt_l_out) begin
            au.bus_out    = pc_q[7:0];
            au.bus_out_en = 1'b1;
        end else if (au.cnt_h_out) begin
            au.bus_out    = pc_q[15:8];
            au.bus_out_en = 1'b1;
        end
    end

    assign au.pc         = pc_q;
    assign au.mreg       = mreg_q;
    assign au.halted     = halted_q;
    assign au.pc_wrap    = wrap_q;
    assign au.strobe_err = err_q;
endmodule

// File: tb/tb_addr_unit.sv
// Directed-vector bench for addr_unit: the driver queues hand-computed expectations per cycle,
// a monitor pops and compares them at the falling edge.
module tb_addr_unit;
    logic clk;
    logic reset;

    addr_unit_if au ();

    addr_unit #(.RESET_VECTOR(16'h0100)) dut (
        .clk   (clk),
        .reset (reset),
        .au    (au)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] S_MH   = 10'h001;
    localparam logic [9:0] S_ML   = 10'h002;
    localparam logic [9:0] S_EN   = 10'h004;
    localparam logic [9:0] S_WR   = 10'h008;
    localparam logic [9:0] S_LO   = 10'h010;
    localparam logic [9:0] S_HO   = 10'h020;
    localparam logic [9:0] S_RPC  = 10'h040;
    localparam logic [9:0] S_RM   = 10'h080;
    localparam logic [9:0] S_RW   = 10'h100;
    localparam logic [9:0] S_HALT = 10'h200;

    typedef struct {
        int          step;
        logic [15:0] addr;
        logic [7:0]  bus;
        logic        en;
        logic [15:0] pc;
        logic [15:0] mreg;
        logic        h;
        logic        w;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;

    task automatic chk(input string nm, input int stp, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL step %0d %s: got %h expected %h", stp, nm, got, exp);
    endtask

    task automatic step(input logic [9:0] s, input logic [7:0] b,
                        input logic [15:0] e_addr, input logic [7:0] e_bus, input logic e_en,
                        input logic [15:0] e_pc, input logic [15:0] e_mreg,
                        input logic e_h, input logic e_w, input logic e_e);
        exp_t x;
        au.mreg_h_load   = s[0];
        au.mreg_l_load   = s[1];
        au.cnt_en        = s[2];
        au.cnt_wr        = s[3];
        au.cnt_l_out     = s[4];
        au.cnt_h_out     = s[5];
        au.ram_read_pc   = s[6];
        au.ram_read_mreg = s[7];
        au.ram_write     = s[8];
        au.halt          = s[9];
        au.bus_in        = b;
        step_no++;
        x.step = step_no; x.addr = e_addr; x.bus = e_bus; x.en = e_en;
        x.pc = e_pc; x.mreg = e_mreg; x.h = e_h; x.w = e_w; x.e = e_e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step();
        reset = 1'b0;
        step(10'h000, 8'h00, 16'h0100, 8'h00, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // Monitor: compare the current cycle's outputs against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("addr",       x.step, au.addr, x.addr);
                chk("bus_out",    x.step, {8'h00, au.bus_out}, {8'h00, x.bus});
                chk("bus_out_en", x.step, {15'h0, au.bus_out_en}, {15'h0, x.en});
                chk("pc",         x.step, au.pc, x.pc);
                chk("mreg",       x.step, au.mreg, x.mreg);
                chk("halted",     x.step, {15'h0, au.halted}, {15'h0, x.h});
                chk("pc_wrap",    x.step, {15'h0, au.pc_wrap}, {15'h0, x.w});
                chk("strobe_err", x.step, {15'h0, au.strobe_err}, {15'h0, x.e});
            end
        end
    end

    initial begin
        int wait_cyc;
        reset = 1'b0;
        au.bus_in = 8'h00; au.mreg_h_load = 0; au.mreg_l_load = 0; au.cnt_en = 0; au.cnt_wr = 0;
        au.cnt_l_out = 0; au.cnt_h_out = 0; au.ram_read_pc = 0; au.ram_read_mreg = 0;
        au.ram_write = 0; au.halt = 0;
        @(posedge clk);
        #1;
        // reset, then three fetches
        rst_step();
        step(10'h000,       8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 0);
        step(S_RPC | S_EN,  8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 0);
        step(S_RPC | S_EN,  8'h00, 16'h0101, 8'h00, 0, 16'h0101, 16'h0000, 0, 0, 0);
        step(S_RPC | S_EN,  8'h00, 16'h0102, 8'h00, 0, 16'h0102, 16'h0000, 0, 0, 0);
        step(10'h000,       8'h00, 16'h0103, 8'h00, 0, 16'h0103, 16'h0000, 0, 0, 0);
        // jump sequence
        step(S_MH,          8'h12, 16'h0103, 8'h00, 0, 16'h0103, 16'h0000, 0, 0, 0);
        step(S_ML,          8'h34, 16'h0103, 8'h00, 0, 16'h0103, 16'h1200, 0, 0, 0);
        step(S_WR,          8'h00, 16'h0103, 8'h00, 0, 16'h0103, 16'h1234, 0, 0, 0);
        step(S_RPC,         8'h00, 16'h1234, 8'h00, 0, 16'h1234, 16'h1234, 0, 0, 0);
        // jump + increment + MREG load in one cycle
        step(S_WR|S_EN|S_ML, 8'h56, 16'h1234, 8'h00, 0, 16'h1234, 16'h1234, 0, 0, 0);
        step(S_RM,          8'h00, 16'h1256, 8'h00, 0, 16'h1234, 16'h1256, 0, 0, 0);
        // wrap by increment
        step(S_MH|S_ML|S_RW, 8'hFF, 16'h1256, 8'h00, 0, 16'h1234, 16'h1256, 0, 0, 0);
        step(S_WR,          8'h00, 16'h1234, 8'h00, 0, 16'h1234, 16'hFFFF, 0, 0, 0);
        step(S_EN,          8'h00, 16'hFFFF, 8'h00, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        step(S_MH | S_ML,   8'h00, 16'h0000, 8'h00, 0, 16'h0000, 16'hFFFF, 0, 1, 0);
        step(S_MH | S_ML,   8'hFF, 16'h0000, 8'h00, 0, 16'h0000, 16'h0000, 0, 0, 0);
        // jump FFFF -> 0000 must not pulse pc_wrap
        step(S_WR,          8'h00, 16'h0000, 8'h00, 0, 16'h0000, 16'hFFFF, 0, 0, 0);
        step(S_MH | S_ML,   8'h00, 16'hFFFF, 8'h00, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        step(S_WR | S_EN,   8'h00, 16'hFFFF, 8'h00, 0, 16'hFFFF, 16'h0000, 0, 0, 0);
        step(S_RM,          8'h00, 16'h0000, 8'h00, 0, 16'h0000, 16'h0000, 0, 0, 0);
        // halt freezes PC and MREG
        step(S_ML,          8'hA5, 16'h0000, 8'h00, 0, 16'h0000, 16'h0000, 0, 0, 0);
        step(S_WR,          8'h00, 16'h0000, 8'h00, 0, 16'h0000, 16'h00A5, 0, 0, 0);
        step(S_HALT,        8'h00, 16'h00A5, 8'h00, 0, 16'h00A5, 16'h00A5, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(S_EN | S_MH, 8'h77, 16'h00A5, 8'h00, 0, 16'h00A5, 16'h00A5, 1, 0, 0);
        step(S_LO,          8'h00, 16'h00A5, 8'hA5, 1, 16'h00A5, 16'h00A5, 1, 0, 0);
        step(S_HO,          8'h00, 16'h00A5, 8'h00, 1, 16'h00A5, 16'h00A5, 1, 0, 0);
        // reset pulse clears halt
        rst_step();
        step(10'h000,       8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 0);
        // strobe errors and mux priority in the offending cycle
        step(S_RPC | S_RW,  8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 0);
        step(10'h000,       8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 1);
        step(S_LO | S_HO,   8'h00, 16'h0100, 8'h00, 1, 16'h0100, 16'h0000, 0, 0, 1);
        step(S_RM | S_RW,   8'h00, 16'h0000, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 1);
        rst_step();
        step(S_HO,          8'h00, 16'h0100, 8'h01, 1, 16'h0100, 16'h0000, 0, 0, 0);
        step(S_LO | S_HO,   8'h00, 16'h0100, 8'h00, 1, 16'h0100, 16'h0000, 0, 0, 0);
        step(10'h000,       8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 1);
        rst_step();
        step(10'h000,       8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 0);
        step(S_RM | S_RW,   8'h00, 16'h0000, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 0);
        step(10'h000,       8'h00, 16'h0100, 8'h00, 0, 16'h0100, 16'h0000, 0, 0, 1);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
